// File: rtl/iram_loader_if.sv
// Byte-stream and IRAM write-port bundle for iram_loader.
// The master modport is the environment side and the slave modport is the loader side.
interface iram_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, busy, done, error
    );
endinterface

// File: rtl/iram_loader.sv
// IRAM program loader: count byte N, then N big-endian words written from BASE_ADDR upward.
// Defining IRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the sticky error flag.
//
//   state   | meaning
//   IDLE    | waiting for start
//   COUNT   | receiving word count N (0 means 256)
//   HI      | receiving high byte of the next word
//   LO      | receiving low byte of the next word
//   WRITE   | one-cycle IRAM write strobe
//   CHECK   | receiving trailing checksum byte
//   DONE    | one-cycle done pulse
module iram_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic          clock,
    input  logic          reset,
    iram_loader_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]  state_q,    state_d;
    logic [7:0]  addr_q,     addr_d;
    logic [8:0]  remain_q,   remain_d;
    logic [7:0]  hi_q,       hi_d;
    logic        wr_en_q,    wr_en_d;
    logic [7:0]  wr_addr_q,  wr_addr_d;
    logic [15:0] wr_data_q,  wr_data_d;
    logic        rx_ready_q, rx_ready_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;
    logic        xfer;
`ifdef IRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,     csum_d;
    logic        error_q,    error_d;
`endif

    assign xfer = bus.rx_valid & rx_ready_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        hi_d      = hi_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IRAM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        error_d   = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_COUNT;
                    addr_d  = BASE_ADDR;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
                    error_d = 1'b0;
`endif
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    remain_d = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                    state_d  = S_HI;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ bus.rx_data;
`endif
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = bus.rx_data;
                    state_d = S_LO;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ bus.rx_data;
`endif
                end
            end
            S_LO: begin
                if (xfer) begin
                    // Write port is loaded here so it only changes on the strobe cycle.
                    wr_data_d = {hi_q, bus.rx_data};
                    wr_addr_d = addr_q;
                    state_d   = S_WRITE;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q ^ bus.rx_data;
`endif
                end
            end
            S_WRITE: begin
                addr_d   = addr_q + 8'd1;
                remain_d = remain_q - 9'd1;
                if (remain_q == 9'd1) begin
`ifdef IRAM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_d = S_DONE;
`ifdef IRAM_LOADER_CHECKSUM_EN
                    if (bus.rx_data != csum_q) error_d = 1'b1;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered decodes of the next state.
        rx_ready_d = state_d inside {S_COUNT, S_HI, S_LO, S_CHECK};
        wr_en_d    = (state_d == S_WRITE);
        busy_d     = state_d inside {S_COUNT, S_HI, S_LO, S_WRITE, S_CHECK};
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE_ADDR;
            remain_q   <= 9'd0;
            hi_q       <= 8'h00;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            wr_data_q  <= 16'h0000;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            hi_q       <= hi_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef IRAM_LOADER_CHECKSUM_EN
    assign bus.error    = error_q;
`else
    assign bus.error    = 1'b0;
`endif
endmodule
